// File: rtl/moxie_mem_pkg.sv
// Shared definitions for the moxie memory controllers: controller state
// encoding and the wait-state counter width.
package moxie_mem_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_WREC  = 3'd3,
      ST_ACK   = 3'd4
   } state_e;

endpackage

// File: rtl/wb_sram16.sv
// Wishbone slave bridging 16-bit accesses onto an asynchronous SRAM with
// fixed read/write wait states; every SRAM-facing output is a flop.
module wb_sram16
   import moxie_mem_pkg::*;
#(
   parameter int unsigned AW      = 18,
   parameter int unsigned RD_WAIT = 2,
   parameter int unsigned WR_WAIT = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [31:0]   wb_adr_i,
   input  logic [15:0]   wb_dat_i,
   input  logic [1:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   output logic [15:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic [AW-1:0] sram_adr_o,
   output logic [15:0]   sram_dq_o,
   output logic          sram_dq_oe_o,
   input  logic [15:0]   sram_dq_i,
   output logic          sram_ce_n_o,
   output logic          sram_oe_n_o,
   output logic          sram_we_n_o,
   output logic          sram_ub_n_o,
   output logic          sram_lb_n_o
);

   if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
      $error("wb_sram16: RD_WAIT must be within 1..15");
   end
   if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
      $error("wb_sram16: WR_WAIT must be within 1..15");
   end

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

   // Upper address bits and the byte-lane bit are decoded upstream.
   logic unused_adr;
   assign unused_adr = ^{wb_adr_i[31:AW+1], wb_adr_i[0]};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    adr_q, adr_d;
   logic [15:0]      dq_q, dq_d;
   logic [1:0]       sel_q, sel_d;
   logic [15:0]      dat_q, dat_d;
   logic             ack_q, ack_d;
   logic             ce_n_q, ce_n_d;
   logic             oe_n_q, oe_n_d;
   logic             we_n_q, we_n_d;
   logic             ub_n_q, ub_n_d;
   logic             lb_n_q, lb_n_d;
   logic             dq_oe_q, dq_oe_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dq_d    = dq_q;
      sel_d   = sel_q;
      dat_d   = dat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               adr_d = wb_adr_i[AW:1];
               dq_d  = wb_dat_i;
               sel_d = wb_sel_i;
               if (wb_we_i) begin
                  state_d = ST_WRITE;
                  cnt_d   = WR_LOAD;
               end else begin
                  state_d = ST_READ;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         ST_READ: begin
            if (cnt_q == '0) begin
               dat_d   = sram_dq_i;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WRITE: begin
            if (cnt_q == '0) begin
               state_d = ST_WREC;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WREC: state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Strobes are decoded from the next state so the flops present them
      // during exactly the cycles spent in that state.
      ce_n_d  = !(state_d inside {ST_READ, ST_WRITE, ST_WREC});
      oe_n_d  = (state_d != ST_READ);
      we_n_d  = !(state_d == ST_WRITE && sel_d != 2'b00);
      dq_oe_d = (state_d inside {ST_WRITE, ST_WREC});
      ack_d   = (state_d == ST_ACK);
      ub_n_d  = 1'b1;
      lb_n_d  = 1'b1;
      if (state_d == ST_READ) begin
         ub_n_d = 1'b0;
         lb_n_d = 1'b0;
      end else if (dq_oe_d) begin
         ub_n_d = !sel_d[1];
         lb_n_d = !sel_d[0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         dq_q    <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dq_q    <= dq_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         ub_n_q  <= ub_n_d;
         lb_n_q  <= lb_n_d;
         dq_oe_q <= dq_oe_d;
      end
   end

   assign wb_dat_o     = dat_q;
   assign wb_ack_o     = ack_q;
   assign sram_adr_o   = adr_q;
   assign sram_dq_o    = dq_q;
   assign sram_dq_oe_o = dq_oe_q;
   assign sram_ce_n_o  = ce_n_q;
   assign sram_oe_n_o  = oe_n_q;
   assign sram_we_n_o  = we_n_q;
   assign sram_ub_n_o  = ub_n_q;
   assign sram_lb_n_o  = lb_n_q;

endmodule
